// File: rtl/gray_fifo_pkg.sv
// Shared gray/binary pointer conversions for the async FIFO write and read controllers.
// Width is passed at call time so one function serves any pointer size up to MAX_PTR_W.
package gray_fifo_pkg;

    localparam int unsigned MAX_PTR_W = 32;

    typedef logic [MAX_PTR_W-1:0] ptr_t;

    // All-ones in the low w bits; a zero width yields an empty mask.
    function automatic ptr_t width_mask(input int unsigned w);
        ptr_t m;
        m = '1;
        if (w < MAX_PTR_W) begin
            m = m >> (MAX_PTR_W - w);
        end
        return m;
    endfunction

    function automatic ptr_t bin2gray(input ptr_t b, input int unsigned w);
        ptr_t bm;
        bm = b & width_mask(w);
        return bm ^ (bm >> 1);
    endfunction

    // Bits above w are masked off, so the running XOR starts from zero at the true MSB.
    function automatic ptr_t gray2bin(input ptr_t g, input int unsigned w);
        ptr_t gm;
        ptr_t b;
        gm = g & width_mask(w);
        b  = '0;
        b[MAX_PTR_W-1] = gm[MAX_PTR_W-1];
        for (int i = int'(MAX_PTR_W) - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ gm[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_ptr_sync.sv
// Multi-flop synchronizer for a gray-coded pointer crossing into the local clock domain.
// Async active-high reset clears every stage to zero.
module gray_ptr_sync #(
    parameter int unsigned WIDTH  = 5,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_async,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] sync_q [STAGES];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(STAGES); i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= d_async;
            for (int i = 1; i < int'(STAGES); i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/gray_fifo_wr_ctrl.sv
// Write-side pointer controller of the gray-coded async FIFO: owns the write pointer,
// syncs the read pointer in, and derives full / almost_full / level / sticky overflow.
module gray_fifo_wr_ctrl
    import gray_fifo_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned SYNC_DLY   = 2,
    parameter int unsigned AF_MARGIN  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic                  ovf_clr,
    input  logic [ADDR_WIDTH:0]   rptr_gray_async,
    output logic                  wr_fire,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [ADDR_WIDTH:0]   wptr_gray,
    output logic                  full,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  wr_overflow
);

    localparam int unsigned PTR_W    = ADDR_WIDTH + 1;
    localparam int unsigned DEPTH    = 1 << ADDR_WIDTH;
    localparam int unsigned AF_LEVEL = DEPTH - AF_MARGIN;

    logic [PTR_W-1:0] bin_q,   bin_d;
    logic [PTR_W-1:0] gray_q,  gray_d;
    logic [PTR_W-1:0] level_q, level_d;
    logic             full_q,  full_d;
    logic             af_q,    af_d;
    logic             ovf_q,   ovf_d;
    logic [PTR_W-1:0] rq;
    logic [PTR_W-1:0] rq_bin;
    logic [PTR_W-1:0] rq_full_pattern;

    gray_ptr_sync #(
        .WIDTH  (PTR_W),
        .STAGES (SYNC_DLY)
    ) u_rptr_sync (
        .clk     (clk),
        .rst     (rst),
        .d_async (rptr_gray_async),
        .q       (rq)
    );

    // Accept gated only by the registered full, so the filling write blocks the next one.
    assign wr_fire = wr_en && !full_q;
    assign waddr   = bin_q[ADDR_WIDTH-1:0];

    // Full when the write pointer leads the read pointer by exactly one lap (top two gray bits inverted).
    assign rq_full_pattern = {~rq[ADDR_WIDTH:ADDR_WIDTH-1], rq[ADDR_WIDTH-2:0]};
    assign rq_bin          = PTR_W'(gray2bin(MAX_PTR_W'(rq), PTR_W));

    always_comb begin
        bin_d   = bin_q;
        gray_d  = gray_q;
        level_d = level_q;
        full_d  = full_q;
        af_d    = af_q;
        ovf_d   = ovf_q;

        if (wr_fire) begin
            bin_d = bin_q + PTR_W'(1);
        end
        gray_d  = PTR_W'(bin2gray(MAX_PTR_W'(bin_d), PTR_W));
        full_d  = (gray_d == rq_full_pattern);
        level_d = bin_d - rq_bin;
        af_d    = (level_d >= PTR_W'(AF_LEVEL));

        // A new overflow takes priority over a simultaneous clear.
        if (wr_en && full_q) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin_q   <= '0;
            gray_q  <= '0;
            level_q <= '0;
            full_q  <= 1'b0;
            af_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            bin_q   <= bin_d;
            gray_q  <= gray_d;
            level_q <= level_d;
            full_q  <= full_d;
            af_q    <= af_d;
            ovf_q   <= ovf_d;
        end
    end

    assign wptr_gray   = gray_q;
    assign full        = full_q;
    assign almost_full = af_q;
    assign level       = level_q;
    assign wr_overflow = ovf_q;

endmodule

// File: tb/tb_gray_fifo_wr_ctrl.sv
// Self-checking bench for gray_fifo_wr_ctrl: fill table, overflow, sync latency, wrap and steady-level sequences.
module tb_gray_fifo_wr_ctrl;

    localparam int unsigned AW = 4;
    localparam int unsigned PW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic          ovf_clr;
    logic [PW-1:0] rptr;
    logic          wr_fire;
    logic [AW-1:0] waddr;
    logic [PW-1:0] wptr_gray;
    logic          full;
    logic          almost_full;
    logic [PW-1:0] level;
    logic          wr_overflow;

    gray_fifo_wr_ctrl #(
        .ADDR_WIDTH (4),
        .SYNC_DLY   (2),
        .AF_MARGIN  (2)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .wr_en           (wr_en),
        .ovf_clr         (ovf_clr),
        .rptr_gray_async (rptr),
        .wr_fire         (wr_fire),
        .waddr           (waddr),
        .wptr_gray       (wptr_gray),
        .full            (full),
        .almost_full     (almost_full),
        .level           (level),
        .wr_overflow     (wr_overflow)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [PW-1:0] gray;
        logic          full;
        logic          af;
        logic [PW-1:0] level;
        logic          ovf;
    } exp_t;

    exp_t sbq[$];

    // Bench-side reference state, updated once per clock edge.
    logic [PW-1:0] m_bin;
    logic [PW-1:0] m_s0;
    logic [PW-1:0] m_s1;
    logic          m_full;
    logic [PW-1:0] m_level;
    logic          m_af;
    logic          m_ovf;

    typedef struct {
        logic          we;
        logic [AW-1:0] waddr;
        logic          fire;
        logic [PW-1:0] level;
        logic          full;
        logic          af;
    } vec_t;

    vec_t vt[17];

    function automatic logic [PW-1:0] g(input logic [PW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [PW-1:0] g2b(input logic [PW-1:0] x);
        logic [PW-1:0] b;
        b[PW-1] = x[PW-1];
        for (int i = PW - 2; i >= 0; i--) b[i] = b[i+1] ^ x[i];
        return b;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_bin = '0; m_s0 = '0; m_s1 = '0;
        m_full = 1'b0; m_level = '0; m_af = 1'b0; m_ovf = 1'b0;
        sbq.delete();
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_wr_fire"},   32'(wr_fire), 32'd0);
        chk({tag, "_waddr"},     32'(waddr), 32'd0);
        chk({tag, "_wptr_gray"}, 32'(wptr_gray), 32'd0);
        chk({tag, "_full"},      32'(full), 32'd0);
        chk({tag, "_af"},        32'(almost_full), 32'd0);
        chk({tag, "_level"},     32'(level), 32'd0);
        chk({tag, "_ovf"},       32'(wr_overflow), 32'd0);
    endtask

    // Called at posedge+1; pulses rst mid-cycle and checks outputs before the next edge.
    task automatic do_reset();
        wr_en = 1'b0; ovf_clr = 1'b0; rptr = '0;
        #1 rst = 1'b1;
        #1 chk_zero("rst_mid");
        #1 rst = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    // One clock: drive, check combinational outputs, push expectation, clock, pop and compare.
    task automatic step(input logic we, input logic clr, input logic [PW-1:0] rp);
        logic          fire;
        logic [PW-1:0] rq;
        exp_t          e;
        wr_en = we; ovf_clr = clr; rptr = rp;
        #1;
        fire = we && !m_full;
        chk("wr_fire", 32'(wr_fire), 32'(fire));
        chk("waddr", 32'(waddr), 32'(m_bin[AW-1:0]));
        if (we && m_full) m_ovf = 1'b1;
        else if (clr)     m_ovf = 1'b0;
        if (fire) m_bin = m_bin + 5'd1;
        rq   = m_s1;
        m_s1 = m_s0;
        m_s0 = rp;
        m_full  = (g(m_bin) == {~rq[4:3], rq[2:0]});
        m_level = m_bin - g2b(rq);
        m_af    = (m_level >= 5'd14);
        sbq.push_back('{gray: g(m_bin), full: m_full, af: m_af, level: m_level, ovf: m_ovf});
        @(posedge clk);
        #1;
        if (sbq.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sbq.pop_front();
            chk("sb_wptr_gray", 32'(wptr_gray), 32'(e.gray));
            chk("sb_full", 32'(full), 32'(e.full));
            chk("sb_af", 32'(almost_full), 32'(e.af));
            chk("sb_level", 32'(level), 32'(e.level));
            chk("sb_ovf", 32'(wr_overflow), 32'(e.ovf));
        end
    endtask

    initial begin
        logic [PW-1:0] prev;
        logic [PW-1:0] rp;
        logic          wrap_seen;

        for (int i = 0; i < 16; i++) begin
            vt[i] = '{we: 1'b1, waddr: AW'(i), fire: 1'b1, level: PW'(i + 1),
                      full: (i == 15), af: ((i + 1) >= 14)};
        end
        vt[16] = '{we: 1'b1, waddr: 4'd0, fire: 1'b0, level: 5'd16, full: 1'b1, af: 1'b1};

        rst = 1'b1; wr_en = 1'b0; ovf_clr = 1'b0; rptr = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_zero("rst_init");
        rst = 1'b0;

        step(1'b1, 1'b0, 5'd0);
        step(1'b1, 1'b0, 5'd0);
        step(1'b1, 1'b0, 5'd0);
        do_reset();

        // Fill from empty with the read pointer parked at zero, then one overflowing write.
        for (int i = 0; i < 17; i++) begin
            wr_en = vt[i].we; ovf_clr = 1'b0; rptr = '0;
            #1;
            chk("tbl_fire", 32'(wr_fire), 32'(vt[i].fire));
            chk("tbl_waddr", 32'(waddr), 32'(vt[i].waddr));
            step(vt[i].we, 1'b0, 5'd0);
            chk("tbl_level", 32'(level), 32'(vt[i].level));
            chk("tbl_full", 32'(full), 32'(vt[i].full));
            chk("tbl_af", 32'(almost_full), 32'(vt[i].af));
            if (i >= 15) chk("tbl_wptr_gray", 32'(wptr_gray), 32'h18);
        end
        chk("ovf_set", 32'(wr_overflow), 32'd1);

        step(1'b0, 1'b0, 5'd0);
        chk("ovf_hold", 32'(wr_overflow), 32'd1);
        step(1'b1, 1'b1, 5'd0);
        chk("ovf_set_beats_clr", 32'(wr_overflow), 32'd1);
        step(1'b0, 1'b1, 5'd0);
        chk("ovf_cleared", 32'(wr_overflow), 32'd0);

        // Read pointer jumps to gray(4): effect lands on the third edge.
        step(1'b0, 1'b0, 5'b00110);
        chk("sync_e1_full", 32'(full), 32'd1);
        step(1'b0, 1'b0, 5'b00110);
        chk("sync_e2_full", 32'(full), 32'd1);
        chk("sync_e2_level", 32'(level), 32'd16);
        step(1'b0, 1'b0, 5'b00110);
        chk("sync_e3_full", 32'(full), 32'd0);
        chk("sync_e3_level", 32'(level), 32'd12);
        chk("sync_e3_af", 32'(almost_full), 32'd0);

        // Continuous writes with the reader trailing by two, across the pointer wrap.
        do_reset();
        step(1'b1, 1'b0, 5'd0);
        step(1'b1, 1'b0, 5'd0);
        wrap_seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            rp   = g(m_bin - 5'd2);
            prev = wptr_gray;
            step(1'b1, 1'b0, rp);
            chk("wrap_one_bit", 32'($countones(wptr_gray ^ prev)), 32'd1);
            chk("wrap_no_full", 32'(full), 32'd0);
            if (prev == 5'b10000 && wptr_gray == 5'b00000) wrap_seen = 1'b1;
        end
        chk("wrap_seen", 32'(wrap_seen), 32'd1);

        // Writer and reader both advance every cycle with eight entries in flight.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            rp = (i == 6) ? g(5'd1) : (i == 7) ? g(5'd2) : 5'd0;
            step(1'b1, 1'b0, rp);
        end
        chk("steady_start_level", 32'(level), 32'd8);
        for (int k = 3; k < 33; k++) begin
            step(1'b1, 1'b0, g(PW'(k)));
            chk("steady_level", 32'(level), 32'd8);
            chk("steady_no_ovf", 32'(wr_overflow), 32'd0);
            chk("steady_no_full", 32'(full), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
